dmem_scan_arbiter: RTL and testbench
====================================

// Module: dmem_scan_arbiter
// PURPOSE
//  Shares the single read/write port of the MEM-stage data RAM (async-read, sync-write)
//  between the pipeline (priority) and a display-scan engine. The scan engine periodically
//  reads one word (auto-incrementing or switch-selected address) and latches it for the
//  7-segment display, so a second RAM read port is not needed.
// PARAMETERS
//  ADDR_W      6         RAM word-address width
//  DATA_W      32        RAM data width
//  TICK_MAX    20000000  scan period: one tick every TICK_MAX+1 clk cycles
//  STARVE_MAX  4         max consecutive S_PEND cycles the scan yields to cpu_req (>=1)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-low reset
//  cpu_req      in   1       MEM stage accesses RAM this cycle (load or store)
//  cpu_we       in   1       store when cpu_req=1
//  cpu_addr     in   ADDR_W  MEM-stage word address (ALU result [7:2])
//  cpu_wdata    in   DATA_W  store data
//  cpu_rdata    out  DATA_W  load data = ram_rdata (combinational)
//  cpu_stall    out  1       cpu_req not serviced this cycle; MEM stage holds
//  select_mode  in   1       1 = auto-increment scan, 0 = manual_addr scan
//  manual_addr  in   ADDR_W  switch-selected display address
//  ram_addr     out  ADDR_W  RAM address
//  ram_we       out  1       RAM write enable
//  ram_wdata    out  DATA_W  RAM write data (= cpu_wdata)
//  ram_rdata    in   DATA_W  RAM async read data
//  disp_word    out  DATA_W  last scanned word (registered)
//  disp_addr    out  ADDR_W  address of disp_word (registered)
//  disp_update  out  1       one-cycle pulse when disp_word/disp_addr change
// BEHAVIOUR
//  Reset: FSM=S_IDLE, tick_cnt=0, auto_ptr=0, starve_cnt=0, disp_word=0, disp_addr=0,
//   disp_update=0; cpu_stall=0; ram_we=cpu_req&cpu_we (combinational, 0 if no cpu_req).
//  Tick: tick_cnt counts 0..TICK_MAX; at TICK_MAX it wraps to 0 and asserts tick for one cycle.
//   A manual_addr change (registered compare) while select_mode=0 also raises tick.
//  scan_addr = select_mode ? auto_ptr : manual_addr (sampled in S_SCAN).
//  FSM:
//   S_IDLE: port owned by CPU. tick -> S_PEND (starve_cnt=0).
//   S_PEND: port owned by CPU. If cpu_req=0 -> S_SCAN. If cpu_req=1: starve_cnt++;
//     if starve_cnt==STARVE_MAX-1 -> S_SCAN. Further ticks merge (no queueing).
//   S_SCAN (exactly 1 cycle): ram_addr=scan_addr, ram_we=0, cpu_stall=cpu_req.
//     Clock edge: disp_word<=ram_rdata, disp_addr<=scan_addr, disp_update<=1 (next cycle
//     only); if select_mode, auto_ptr<=auto_ptr+1 (63 wraps to 0). Next: S_PEND if tick
//     occurred during this cycle, else S_IDLE.
//  Outside S_SCAN: ram_addr=cpu_addr, cpu_stall=0; a stalled store is never written.
//  Scan latency from tick with cpu_req=0: S_PEND 1 cycle, S_SCAN 1 cycle, disp_update on
//   the 3rd cycle after tick. Worst case with cpu_req=1: STARVE_MAX+2 cycles.
//  Mode switch: auto_ptr is retained; it is cleared only by reset.
//  Reset mid-operation: immediate return to reset values; a pending scan is dropped.
// TESTING (TICK_MAX=4, STARVE_MAX=4; RAM preloaded mem[i]=i*32'h11)
//  1 Auto mode, cpu_req=0: disp_update every 5 cycles, disp_addr 0,1,2..; disp_word=addr*'h11;
//    after 64 scans disp_addr wraps 63->0.
//  2 cpu_req=1 continuously: after tick, 4 S_PEND cycles, then exactly 1 cycle with
//    cpu_stall=1 and ram_we=0; the stall never occurs outside S_SCAN.
//  3 Store 32'hDEADBEEF to addr 5, then manual mode with manual_addr=5 -> disp_word=DEADBEEF,
//    disp_addr=5.
//  4 Manual mode: change manual_addr 3->9 between ticks -> disp_update with disp_addr=9
//    within 4 cycles, without waiting for the period.
//  5 Tick during S_SCAN -> second scan follows (no lost tick); two ticks in S_PEND -> one scan.
//  6 Assert reset during S_PEND and again during S_SCAN -> all outputs at reset values,
//    disp_update stays 0, and auto_ptr=0 afterwards.

Source files
------------

// File: rtl/dmem_scan_arbiter_if.sv
// CPU-side access port of the MEM-stage data RAM as seen through the scan arbiter.
// The MEM stage is the master; the arbiter is the slave and may stall it.
interface dmem_scan_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall
  );
endinterface

// File: rtl/dmem_scan_arbiter.sv
// Shares the single port of the MEM-stage data RAM between the pipeline (priority) and a
// display-scan engine that periodically reads one word and latches it for the 7-seg display.
module dmem_scan_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int TICK_MAX   = 20000000,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  dmem_scan_arbiter_if.slave cpu,
  input  logic              select_mode,
  input  logic [ADDR_W-1:0] manual_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] disp_word,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              disp_update
);

  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX + 1) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_MAX);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_SCAN
  } state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [ADDR_W-1:0]   auto_ptr;
  logic [ADDR_W-1:0]   manual_q;
  logic                period_tick;
  logic                manual_tick;
  logic                tick;
  logic                in_scan;
  logic [ADDR_W-1:0]   scan_addr;

  // A new switch setting in manual mode refreshes the display without waiting a full period.
  assign period_tick = (tick_cnt == TICK_LAST);
  assign manual_tick = !select_mode && (manual_addr != manual_q);
  assign tick        = period_tick | manual_tick;

  assign scan_addr = select_mode ? auto_ptr : manual_addr;
  assign in_scan   = (state == S_SCAN);

  // The scan owns the port for exactly one cycle; a CPU access in that cycle is held off.
  assign ram_addr      = in_scan ? scan_addr : cpu.cpu_addr;
  assign ram_we        = cpu.cpu_req & cpu.cpu_we & ~in_scan;
  assign ram_wdata     = cpu.cpu_wdata;
  assign cpu.cpu_rdata = ram_rdata;
  assign cpu.cpu_stall = in_scan & cpu.cpu_req;

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order across always_ff blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      manual_q <= '0;
    end else begin
      tick_cnt <= period_tick ? '0 : tick_cnt + 1'b1;
      manual_q <= manual_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      starve_cnt  <= '0;
      auto_ptr    <= '0;
      disp_word   <= '0;
      disp_addr   <= '0;
      disp_update <= 1'b0;
    end else begin
      disp_update <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            state      <= S_PEND;
            starve_cnt <= '0;
          end
        end
        S_PEND: begin
          // Ticks arriving here merge into the one pending scan.
          if (!cpu.cpu_req) begin
            state <= S_SCAN;
          end else begin
            starve_cnt <= starve_cnt + 1'b1;
            if (starve_cnt == STARVE_LAST) state <= S_SCAN;
          end
        end
        S_SCAN: begin
          disp_word   <= ram_rdata;
          disp_addr   <= scan_addr;
          disp_update <= 1'b1;
          if (select_mode) auto_ptr <= auto_ptr + 1'b1;
          starve_cnt <= '0;
          state      <= tick ? S_PEND : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_scan_arbiter.sv
// Directed bench for dmem_scan_arbiter with TICK_MAX=4, STARVE_MAX=4 and a behavioural
// async-read / sync-write RAM preloaded with mem[i] = i*'h11.
module tb_dmem_scan_arbiter;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int TICK_MAX   = 4;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              select_mode;
  logic [ADDR_W-1:0] manual_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] disp_word;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_update;
  logic [DATA_W-1:0] mem [64];

  int cyc   = 0;
  int rel   = 0;
  int n_vec = 0;
  int n_err = 0;

  dmem_scan_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu ();

  dmem_scan_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_MAX(TICK_MAX), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu.slave),
    .select_mode(select_mode),
    .manual_addr(manual_addr),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .disp_word  (disp_word),
    .disp_addr  (disp_addr),
    .disp_update(disp_update)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = i * 32'h11;
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 after release has tick_cnt=0; cycle c satisfies cyc == rel + c.
  task automatic do_reset(input logic mode);
    reset           = 1'b0;
    select_mode     = mode;
    manual_addr     = '0;
    cpu.cpu_req     = 1'b0;
    cpu.cpu_we      = 1'b0;
    cpu.cpu_addr    = 6'd20;
    cpu.cpu_wdata   = '0;
    repeat (2) next_cycle();
    reset = 1'b1;
    rel   = cyc;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < rel + c) next_cycle();
  endtask

  task automatic wait_update(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      next_cycle();
      #1;
      if (disp_update) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, output logic [DATA_W-1:0] rdata);
    int tries;
    tries         = 0;
    cpu.cpu_req   = 1'b1;
    cpu.cpu_we    = we;
    cpu.cpu_addr  = addr;
    cpu.cpu_wdata = wdata;
    #1;
    while (cpu.cpu_stall && tries < 4) begin
      next_cycle();
      #1;
      tries++;
    end
    check("acc_stall_bound", {31'd0, cpu.cpu_stall}, 32'd0);
    rdata = cpu.cpu_rdata;
    next_cycle();
    cpu.cpu_req = 1'b0;
    cpu.cpu_we  = 1'b0;
  endtask

  // Manual-mode timeline: display address latched at each update cycle, -1 if none.
  function automatic int upd_addr(input int c);
    case (c)
      4, 7:   return 3;
      11:     return 9;
      15, 17: return 12;
      24, 30: return 7;
      default: return -1;
    endcase
  endfunction

  initial begin
    int at, prev, sa, ua;
    logic [DATA_W-1:0] rd;

    // Reset state and auto-mode scan cadence with wrap 63 -> 0.
    do_reset(1'b1);
    #1;
    check("rst_disp_word", disp_word, 32'd0);
    check("rst_disp_addr", {26'd0, disp_addr}, 32'd0);
    check("rst_disp_update", {31'd0, disp_update}, 32'd0);
    check("rst_stall", {31'd0, cpu.cpu_stall}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    prev = rel;
    for (int i = 0; i < 65; i++) begin
      wait_update(10, at);
      check("t1_seen", {31'd0, at >= 0}, 32'd1);
      check("t1_addr", {26'd0, disp_addr}, i % 64);
      check("t1_word", disp_word, (i % 64) * 32'h11);
      check("t1_gap", at - prev, (i == 0) ? 7 : 5);
      prev = at;
    end

    // Continuous CPU traffic: 4 yielding cycles, then a single stalled scan cycle.
    cpu.cpu_req   = 1'b1;
    cpu.cpu_we    = 1'b1;
    cpu.cpu_addr  = 6'd40;
    cpu.cpu_wdata = 40 * 32'h11;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) next_cycle();
      #1;
      check("t2_stall", {31'd0, cpu.cpu_stall}, (c == 7 || c == 12) ? 32'd1 : 32'd0);
      check("t2_ram_we", {31'd0, ram_we}, (c == 7 || c == 12) ? 32'd0 : 32'd1);
      check("t2_ram_addr", {26'd0, ram_addr}, (c == 7) ? 32'd1 : (c == 12) ? 32'd2 : 32'd40);
      check("t2_update", {31'd0, disp_update}, (c == 0 || c == 8) ? 32'd1 : 32'd0);
      if (c == 8) begin
        check("t2_disp_addr", {26'd0, disp_addr}, 32'd1);
        check("t2_disp_word", disp_word, 32'h11);
      end
    end

    // Store (first attempt lands in a scan cycle), read back, then display it manually.
    cpu_access(1'b1, 6'd5, 32'hDEADBEEF, rd);
    cpu_access(1'b0, 6'd5, 32'd0, rd);
    check("t3_load", rd, 32'hDEADBEEF);
    select_mode = 1'b0;
    manual_addr = 6'd5;
    wait_update(12, at);
    check("t3_seen", {31'd0, at >= 0}, 32'd1);
    check("t3_disp_addr", {26'd0, disp_addr}, 32'd5);
    check("t3_disp_word", disp_word, 32'hDEADBEEF);

    // Reset during S_SCAN (found via the stall), then during S_PEND.
    select_mode  = 1'b1;
    cpu.cpu_req  = 1'b1;
    cpu.cpu_we   = 1'b0;
    cpu.cpu_addr = 6'd40;
    at = -1;
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      #1;
      if (cpu.cpu_stall) begin
        at = cyc;
        break;
      end
    end
    check("t6_scan_found", {31'd0, at >= 0}, 32'd1);
    reset = 1'b0;
    #1;
    check("t6s_stall", {31'd0, cpu.cpu_stall}, 32'd0);
    check("t6s_ram_addr", {26'd0, ram_addr}, 32'd40);
    check("t6s_disp_addr", {26'd0, disp_addr}, 32'd0);
    check("t6s_disp_word", disp_word, 32'd0);
    cpu.cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      check("t6s_update_low", {31'd0, disp_update}, 32'd0);
    end
    reset = 1'b1;
    rel   = cyc;
    goto_cycle(7);
    #1;
    check("t6s_upd0", {31'd0, disp_update}, 32'd1);
    check("t6s_ptr_clear", {26'd0, disp_addr}, 32'd0);
    goto_cycle(12);
    #1;
    check("t6s_upd1", {31'd0, disp_update}, 32'd1);
    check("t6s_addr1", {26'd0, disp_addr}, 32'd1);
    check("t6s_word1", disp_word, 32'h11);
    goto_cycle(15);
    reset = 1'b0;
    #1;
    check("t6p_disp_addr", {26'd0, disp_addr}, 32'd0);
    check("t6p_disp_word", disp_word, 32'd0);
    check("t6p_update", {31'd0, disp_update}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      check("t6p_update_low", {31'd0, disp_update}, 32'd0);
    end
    reset = 1'b1;
    rel   = cyc;
    goto_cycle(6);
    #1;
    check("t6p_no_stale_scan", {31'd0, disp_update}, 32'd0);
    goto_cycle(7);
    #1;
    check("t6p_upd0", {31'd0, disp_update}, 32'd1);
    check("t6p_ptr_clear", {26'd0, disp_addr}, 32'd0);

    // Manual mode: switch-change ticks, tick during S_SCAN, ticks merging in S_PEND.
    do_reset(1'b0);
    for (int c = 1; c <= 30; c++) begin
      goto_cycle(c);
      case (c)
        1:  manual_addr = 6'd3;
        8:  manual_addr = 6'd9;
        12: manual_addr = 6'd12;
        17: cpu.cpu_req = 1'b1;
        18: manual_addr = 6'd7;
        default: ;
      endcase
      #1;
      ua = upd_addr(c);
      sa = upd_addr(c + 1);
      check($sformatf("t45_update_c%0d", c), {31'd0, disp_update}, (ua >= 0) ? 32'd1 : 32'd0);
      if (ua >= 0) begin
        check($sformatf("t45_disp_addr_c%0d", c), {26'd0, disp_addr}, ua);
        check($sformatf("t45_disp_word_c%0d", c), disp_word, ua * 32'h11);
      end
      check($sformatf("t45_ram_addr_c%0d", c), {26'd0, ram_addr}, (sa >= 0) ? sa : 20);
      check($sformatf("t45_stall_c%0d", c), {31'd0, cpu.cpu_stall},
            (c >= 17 && sa >= 0) ? 32'd1 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
